qupls_fu_issue_sink: RTL and testbench

QUPLS_FU_ISSUE_SINK -- requirements
Module: Qupls_fu_issue_sink

---
 rtl/qupls_fu_issue_sink.sv | 110 +++++++++++
 tb/tb_qupls_fu_issue_sink.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qupls_fu_issue_sink.sv
// Issue sink for a functional unit: accepts one ROB index at a time, waits out its latency,
// then holds a writeback until the ROB acks. Define QUPLS_FU_ABORT_EN to abort on stomp.
module qupls_fu_issue_sink #(
   parameter int LAT_W       = 4,
   parameter int ROB_ENTRIES = 16,
   parameter int NDX_W       = $clog2(ROB_ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NDX_W-1:0]       rndx,
   input  logic                   rndxv,
   input  logic [LAT_W-1:0]       lat,
   input  logic [ROB_ENTRIES-1:0] stomp_i,
   input  logic                   wb_ack,
   output logic                   idle,
   output logic                   wb_v,
   output logic [NDX_W-1:0]       wb_rndx,
   output logic                   wb_stomped,
   output logic                   issue_err,
   output logic [15:0]            ops_done
);

`ifdef QUPLS_FU_ABORT_EN
   localparam logic ABORT_EN = 1'b1;
`else
   localparam logic ABORT_EN = 1'b0;
`endif

   localparam logic [LAT_W-1:0] ONE = LAT_W'(1);

   typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

   state_t           state;
   logic [LAT_W-1:0] cnt;
   logic             stomp_seen;
   logic             stomp_new;
   logic             stomp_cur;
   logic [LAT_W-1:0] lat_eff;

   // wb_rndx doubles as the latched index of the in-flight op
   assign stomp_new = stomp_i[rndx];
   assign stomp_cur = stomp_i[wb_rndx];
   assign lat_eff   = (lat == '0) ? ONE : lat;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         idle       <= 1'b1;
         wb_v       <= 1'b0;
         wb_rndx    <= '0;
         wb_stomped <= 1'b0;
         issue_err  <= 1'b0;
         ops_done   <= '0;
         cnt        <= '0;
         stomp_seen <= 1'b0;
      end else begin
         issue_err <= rndxv && (state != IDLE);
         case (state)
            IDLE: begin
               if (rndxv && !stomp_new) begin
                  state      <= BUSY;
                  idle       <= 1'b0;
                  wb_rndx    <= rndx;
                  cnt        <= lat_eff;
                  stomp_seen <= 1'b0;
               end
            end
            BUSY: begin
               if (ABORT_EN && stomp_cur) begin
                  state <= IDLE;
                  idle  <= 1'b1;
                  cnt   <= '0;
               end else begin
                  cnt        <= cnt - ONE;
                  stomp_seen <= stomp_seen | stomp_cur;
                  if (cnt == ONE) begin
                     state      <= WB;
                     wb_v       <= 1'b1;
                     wb_stomped <= stomp_seen | stomp_cur;
                  end
               end
            end
            WB: begin
               // an abort takes priority over a same-cycle ack, so nothing is counted
               if (ABORT_EN && stomp_cur) begin
                  state      <= IDLE;
                  idle       <= 1'b1;
                  wb_v       <= 1'b0;
                  wb_stomped <= 1'b0;
               end else if (wb_ack) begin
                  state      <= IDLE;
                  idle       <= 1'b1;
                  wb_v       <= 1'b0;
                  wb_stomped <= 1'b0;
                  ops_done   <= ops_done + 16'd1;
               end else begin
                  wb_stomped <= wb_stomped | stomp_cur;
               end
            end
            default: begin
               state      <= IDLE;
               idle       <= 1'b1;
               wb_v       <= 1'b0;
               wb_stomped <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qupls_fu_issue_sink.sv
// Self-checking bench for qupls_fu_issue_sink: accepted issues go into a scoreboard queue
// and are matched against writebacks (index, stomp flag, latency) as they appear.
module tb_qupls_fu_issue_sink;

   logic        clk;
   logic        rst;
   logic [3:0]  rndx;
   logic        rndxv;
   logic [3:0]  lat;
   logic [15:0] stomp_i;
   logic        wb_ack;
   logic        idle;
   logic        wb_v;
   logic [3:0]  wb_rndx;
   logic        wb_stomped;
   logic        issue_err;
   logic [15:0] ops_done;

   typedef struct {
      logic [3:0] ndx;
      int         lat;
      int         acc;
      logic       stomped;
   } sb_t;

   sb_t  sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   exp_ops = 0;
   logic wb_v_prev = 1'b0;

   qupls_fu_issue_sink dut (
      .clk        (clk),
      .rst        (rst),
      .rndx       (rndx),
      .rndxv      (rndxv),
      .lat        (lat),
      .stomp_i    (stomp_i),
      .wb_ack     (wb_ack),
      .idle       (idle),
      .wb_v       (wb_v),
      .wb_rndx    (wb_rndx),
      .wb_stomped (wb_stomped),
      .issue_err  (issue_err),
      .ops_done   (ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one issue strobe for a cycle; queue the op when it should be accepted
   task automatic applyStimulus(input logic [3:0] n, input logic [3:0] l, input bit accept);
      sb_t e;
      rndx  = n;
      lat   = l;
      rndxv = 1'b1;
      if (accept) begin
         e.ndx     = n;
         e.lat     = (l == 4'd0) ? 1 : int'(l);
         e.acc     = cyc + 1;
         e.stomped = 1'b0;
         sb_q.push_back(e);
      end
      step();
      rndxv = 1'b0;
      checkOutput("accept_idle", 32'(idle), 32'(!accept));
   endtask

   task automatic waitIdle(input int max_cycles);
      int n;
      n = 0;
      while (!idle && n < max_cycles) begin
         step();
         n++;
      end
      if (!idle) checkOutput("idle_timeout", 32'(idle), 32'd1);
   endtask

   // Scoreboard side: the first cycle of every writeback must match the oldest queued op
   always @(negedge clk) begin
      if (wb_v && !wb_v_prev) begin
         if (sb_q.size() == 0) begin
            checkOutput("wb_unexpected", 32'(wb_v), 32'd0);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            checkOutput("wb_rndx", 32'(wb_rndx), 32'(e.ndx));
            checkOutput("wb_stomped", 32'(wb_stomped), 32'(e.stomped));
            checkOutput("wb_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      wb_v_prev = wb_v;
   end

   initial begin
      rst     = 1'b0;
      rndx    = '0;
      rndxv   = 1'b0;
      lat     = '0;
      stomp_i = '0;
      wb_ack  = 1'b1;
      step();
      checkOutput("rst_idle", 32'(idle), 32'd1);
      checkOutput("rst_wb_v", 32'(wb_v), 32'd0);
      checkOutput("rst_wb_rndx", 32'(wb_rndx), 32'd0);
      checkOutput("rst_wb_stomped", 32'(wb_stomped), 32'd0);
      checkOutput("rst_issue_err", 32'(issue_err), 32'd0);
      checkOutput("rst_ops_done", 32'(ops_done), 32'd0);
      step();
      rst = 1'b1;
      step();

      // Basic issue, latency 3, ack tied high
      applyStimulus(4'd5, 4'd3, 1'b1);
      step();
      checkOutput("lat3_c1_wb_v", 32'(wb_v), 32'd0);
      step();
      checkOutput("lat3_c2_wb_v", 32'(wb_v), 32'd0);
      step();
      checkOutput("lat3_c3_wb_v", 32'(wb_v), 32'd1);
      checkOutput("lat3_c3_rndx", 32'(wb_rndx), 32'd5);
      step();
      exp_ops++;
      checkOutput("lat3_idle", 32'(idle), 32'd1);
      checkOutput("lat3_ops", 32'(ops_done), 32'(exp_ops));

      // Latency code 0 behaves as 1
      applyStimulus(4'd9, 4'd0, 1'b1);
      checkOutput("lat0_c0_wb_v", 32'(wb_v), 32'd0);
      step();
      checkOutput("lat0_c1_wb_v", 32'(wb_v), 32'd1);
      step();
      exp_ops++;
      checkOutput("lat0_ops", 32'(ops_done), 32'(exp_ops));

      // Held writeback, ack ignored while busy, issue while busy flags an error
      wb_ack = 1'b0;
      applyStimulus(4'd2, 4'd4, 1'b1);
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
      checkOutput("busy_ack_idle", 32'(idle), 32'd0);
      checkOutput("busy_ack_ops", 32'(ops_done), 32'(exp_ops));
      step();
      step();
      step();
      checkOutput("hold_wb_v0", 32'(wb_v), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            rndx  = 4'd9;
            lat   = 4'd1;
            rndxv = 1'b1;
         end
         step();
         rndxv = 1'b0;
         checkOutput("hold_wb_v", 32'(wb_v), 32'd1);
         checkOutput("hold_wb_rndx", 32'(wb_rndx), 32'd2);
         checkOutput("hold_issue_err", 32'(issue_err), 32'(i == 1));
      end
      wb_ack = 1'b1;
      rndx   = 4'd3;
      lat    = 4'd1;
      rndxv  = 1'b1;
      step();
      rndxv = 1'b0;
      exp_ops++;
      checkOutput("ack_cycle_idle", 32'(idle), 32'd1);
      checkOutput("ack_cycle_ops", 32'(ops_done), 32'(exp_ops));
      checkOutput("ack_cycle_err", 32'(issue_err), 32'd1);
      step();
      checkOutput("ack_cycle_noaccept", 32'(idle), 32'd1);
      checkOutput("ack_cycle_err_clr", 32'(issue_err), 32'd0);

      // Issue of an already-stomped entry is dropped
      stomp_i = 16'h0040;
      applyStimulus(4'd6, 4'd2, 1'b0);
      stomp_i = '0;
      step();
      checkOutput("drop_idle", 32'(idle), 32'd1);
      checkOutput("drop_ops", 32'(ops_done), 32'(exp_ops));

      // Stomp of the in-flight entry two cycles after accept
      applyStimulus(4'd7, 4'd6, 1'b1);
      step();
      step();
      stomp_i = 16'h0080;
      sb_q[0].stomped = 1'b1;
      step();
      stomp_i = '0;
`ifdef QUPLS_FU_ABORT_EN
      sb_q.delete(0);
      checkOutput("abort_idle", 32'(idle), 32'd1);
      checkOutput("abort_wb_v", 32'(wb_v), 32'd0);
      step();
      checkOutput("abort_ops", 32'(ops_done), 32'(exp_ops));
`else
      checkOutput("stomp_busy", 32'(idle), 32'd0);
      step();
      step();
      checkOutput("stomp_c5_wb_v", 32'(wb_v), 32'd0);
      step();
      checkOutput("stomp_c6_wb_v", 32'(wb_v), 32'd1);
      checkOutput("stomp_c6_flag", 32'(wb_stomped), 32'd1);
      step();
      exp_ops++;
      checkOutput("stomp_ops", 32'(ops_done), 32'(exp_ops));
`endif

      // A handful of random back-to-back ops
      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 1'b1);
         waitIdle(40);
         exp_ops++;
         checkOutput("rand_ops", 32'(ops_done), 32'(exp_ops));
      end

      // Asynchronous reset in the middle of a busy op
      applyStimulus(4'd4, 4'd8, 1'b1);
      step();
      #2;
      rst = 1'b0;
      #1;
      sb_q.delete();
      exp_ops = 0;
      checkOutput("async_rst_idle", 32'(idle), 32'd1);
      checkOutput("async_rst_wb_v", 32'(wb_v), 32'd0);
      checkOutput("async_rst_rndx", 32'(wb_rndx), 32'd0);
      checkOutput("async_rst_ops", 32'(ops_done), 32'd0);
      step();
      rst = 1'b1;
      applyStimulus(4'd1, 4'd1, 1'b1);
      waitIdle(20);
      exp_ops++;
      checkOutput("post_rst_ops", 32'(ops_done), 32'(exp_ops));

      // Completion counter wraps from 0xFFFF to 0
      force dut.ops_done = 16'hFFFF;
      step();
      release dut.ops_done;
      checkOutput("wrap_preload", 32'(ops_done), 32'hFFFF);
      applyStimulus(4'd3, 4'd2, 1'b1);
      waitIdle(20);
      checkOutput("wrap_ops", 32'(ops_done), 32'd0);

      step();
      checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
